// File: rtl/mux_nx1_rr_seq.sv
// Registered N-to-1 channel mux with round-robin or fixed-priority arbitration.
// One output beat register with valid/ready handshake; grants are one-hot and combinational.
module mux_nx1_rr_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUT  = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUT),
    parameter int ARB_MODE   = 0
) (
    input  logic                            CLK,
    input  logic                            rst,
    input  logic                            i_en,
    input  logic [NUM_INPUT-1:0]            i_valid,
    input  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data_bus,
    output logic [NUM_INPUT-1:0]            o_grant,
    output logic                            o_valid,
    output logic [DATA_WIDTH-1:0]           o_data_bus,
    output logic [SEL_WIDTH-1:0]            o_sel,
    input  logic                            i_ready
);

    logic [DATA_WIDTH-1:0] ch [NUM_INPUT];
    logic [SEL_WIDTH-1:0]  ptr_reg;
    logic [SEL_WIDTH-1:0]  ptr_next;
    logic [SEL_WIDTH-1:0]  winner;
    logic                  o_valid_reg;
    logic [DATA_WIDTH-1:0] o_data_reg;
    logic [SEL_WIDTH-1:0]  o_sel_reg;
    logic                  load;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUT; gi++) begin : g_chan
            assign ch[gi]      = i_data_bus[gi*DATA_WIDTH +: DATA_WIDTH];
            assign o_grant[gi] = load && (winner == SEL_WIDTH'(gi));
        end
    endgenerate

    // Scan from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int off = NUM_INPUT - 1; off >= 0; off--) begin
            if (ARB_MODE == 1) begin
                idx = off;
            end else begin
                idx = int'(ptr_reg) + off;
                if (idx >= NUM_INPUT) idx = idx - NUM_INPUT;
            end
            if (i_valid[idx]) winner = SEL_WIDTH'(idx);
        end
    end

    // Wrap explicitly so non-power-of-two channel counts skip unused indices.
    assign ptr_next = (winner == SEL_WIDTH'(NUM_INPUT - 1)) ? '0 : winner + 1'b1;

    assign load = i_en && !rst && (!o_valid_reg || i_ready) && (|i_valid);

    always_ff @(posedge CLK) begin
        if (rst) begin
            o_valid_reg <= 1'b0;
            o_data_reg  <= '0;
            o_sel_reg   <= '0;
            ptr_reg     <= '0;
        end else if (load) begin
            o_valid_reg <= 1'b1;
            o_data_reg  <= ch[winner];
            o_sel_reg   <= winner;
            if (ARB_MODE == 0) ptr_reg <= ptr_next;
        end else if (o_valid_reg && i_ready) begin
            o_valid_reg <= 1'b0;
            o_data_reg  <= '0;
        end
    end

    assign o_valid    = o_valid_reg;
    assign o_data_bus = o_data_reg;
    assign o_sel      = o_sel_reg;

endmodule

// File: doc/mux_nx1_rr_seq.md
# mux_nx1_rr_seq

Registered N-to-1 channel mux with built-in arbitration and a valid/ready handshake. It is the generalised successor of the 2-to-1 sequential mux used in the scaled crossbar. It picks one valid input per cycle, by round-robin or fixed priority, and returns a one-hot grant to the sources. The selected beat is held in a single output register until the downstream stage accepts it. It sits at each crossbar output port, between the input channels and the downstream link register.

## Interface
- DATA_WIDTH, 32, payload width per channel
- NUM_INPUT, 4, number of input channels (≥2, any integer)
- SEL_WIDTH, $clog2(NUM_INPUT), width of the winner index
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

- CLK  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- i_en  in  1  port enable; low blocks new grants
- i_valid  in  NUM_INPUT  per-channel valid
- i_data_bus  in  NUM_INPUT*DATA_WIDTH  channel k at [k*DATA_WIDTH +: DATA_WIDTH]
- o_grant  out  NUM_INPUT  one-hot, combinational; channel k's beat is consumed this cycle when i_valid[k] && o_grant[k]
- o_valid  out  1  output register holds a beat
- o_data_bus  out  DATA_WIDTH  registered payload
- o_sel  out  SEL_WIDTH  registered index of the channel that produced o_data_bus
- i_ready  in  1  downstream accepts the beat this cycle when o_valid && i_ready

## Operation
- Define load = i_en && !rst && (!o_valid || i_ready) && |i_valid.
- Define winner:
  - ARB_MODE=1: the lowest-index k with i_valid[k].
  - ARB_MODE=0: the first k with i_valid[k], scanning ptr, ptr+1, …, NUM_INPUT-1, 0, … (mod NUM_INPUT).
- o_grant = load ? onehot(winner) : 0. It never has more than one bit set and never grants a channel whose i_valid is low.
- On a clock edge with load:
  - o_valid<=1, o_data_bus<=channel[winner], o_sel<=winner.
  - If ARB_MODE=0, ptr<=(winner==NUM_INPUT-1) ? 0 : winner+1.
- On a clock edge without load, when o_valid && i_ready: o_valid<=0, o_data_bus<=0. o_sel holds.
- On a clock edge without load, when o_valid && !i_ready: all outputs and ptr hold (stall). The held beat is never dropped or overwritten.
- ptr changes only on load. Fixed mode ignores ptr.
- i_en low: no grants and no loads. A beat already held drains normally via i_ready, then o_valid stays 0. ptr holds.
- o_data_bus is 0 whenever o_valid is 0.
- Reset wins over everything. On an edge with rst=1:
  - o_valid<=0, o_data_bus<=0, o_sel<=0, ptr<=0.
  - o_grant=0 during that cycle.
  - A beat held mid-stall is discarded.

## Timing
- Latency 1 cycle: a beat granted in cycle t appears on o_data_bus/o_valid in cycle t+1.
- Throughput is 1 beat/cycle with i_ready held high: consume and reload happen on the same edge, with no bubble.
- Simultaneous i_ready and new winner: the held beat is consumed and the new beat loads on the same edge.
- o_grant depends combinationally on i_valid, i_en, i_ready, o_valid, ptr and rst. Sources must not make i_valid depend on o_grant.
- Round-robin fairness: with every channel continuously valid and i_ready=1, each channel is granted exactly once per NUM_INPUT cycles.
- ptr wrap: a winner at NUM_INPUT-1 sets ptr to 0. Non-power-of-two NUM_INPUT wraps at NUM_INPUT, not at 2^SEL_WIDTH.

## Test plan
- Reset, then single channel. Stimulus: rst 2 cycles; i_en=1, i_ready=1; i_valid=4'b0100, ch2=32'hA5A5_0002. Required: o_grant=4'b0100 in cycle 0; in cycle 1 o_valid=1, o_data_bus=32'hA5A5_0002, o_sel=2. With i_valid=0 in cycle 1, o_valid=0 and o_data_bus=0 in cycle 2.
- Round-robin, all valid, ARB_MODE=0, i_ready=1, i_valid=4'b1111 for 8 cycles. Required grant order 0,1,2,3,0,1,2,3, with o_sel lagging by 1 cycle.
- Sparse round-robin. Stimulus: ptr=3 after a grant to ch2, then i_valid=4'b0011. Required: grant ch0 and ptr=1; next grant ch1.
- Fixed priority, ARB_MODE=1, i_valid=4'b1010 held 4 cycles. Required: ch1 granted every cycle, ch3 never.
- Back-pressure. Stimulus: load ch0=32'h1111_1111; i_ready=0 for 3 cycles with i_valid=4'b0010. Required: o_data_bus stays 32'h1111_1111 and o_grant=0 during the stall. On the cycle i_ready=1, o_grant=4'b0010; o_data_bus becomes ch1 on the next edge.
- i_en and rst mid-operation:
  - i_en=0 while holding a beat with i_ready=1. Required: the beat drains once, then o_valid=0 and o_grant=0.
  - rst=1 while a beat is stalled. Required: o_valid=0, o_data_bus=0, o_sel=0 next cycle; the first grant afterwards starts from ch0.
